// File: rtl/vec_pkg.sv
// Shared types and constants for the vector load/store unit.
// Lane count, lane-index width, FSM state encoding and the latched command.
package vec_pkg;

    localparam int VEC_LANES  = 16;
    localparam int LANE_IDX_W = 4;
    localparam int LANE_W     = 8;
    localparam int VRF_IDX_W  = 3;
    localparam int MEM_ADDR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VRD,
        ST_MEM,
        ST_VWR,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic                  store;
        logic [VRF_IDX_W-1:0]  vreg;
        logic [MEM_ADDR_W-1:0] base;
    } cmd_t;

    // Word address of one lane; the sum deliberately wraps at the address width.
    function automatic logic [MEM_ADDR_W-1:0] lane_addr(
        input logic [MEM_ADDR_W-1:0] base,
        input logic [LANE_IDX_W-1:0] idx
    );
        return base + MEM_ADDR_W'(idx);
    endfunction

endpackage

// File: rtl/vec_load_store.sv
// Moves whole vectors between word memory and the vector register file.
// One command at a time; one outstanding memory request per lane.
//
//  state   | meaning
//  IDLE    | ready for a command
//  VRD     | STORE: read VRF register into the lane buffer
//  MEM     | one memory request per lane, 16 in total
//  VWR     | LOAD: write the assembled lane buffer to the VRF
//  DONE    | one-cycle completion pulse, commands refused
module vec_load_store
    import vec_pkg::*;
#(
    parameter int VEC_SIZE        = LANE_W,
    parameter int VEC_INDEX_WIDTH = VRF_IDX_W,
    parameter int ADDR_WIDTH      = MEM_ADDR_W
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_cmd_valid,
    output logic                                  o_cmd_ready,
    input  logic                                  i_cmd_store,
    input  logic [VEC_INDEX_WIDTH-1:0]            i_cmd_vreg,
    input  logic [ADDR_WIDTH-1:0]                 i_cmd_base,
    output logic                                  o_done,
    output logic                                  o_mem_req,
    output logic                                  o_mem_we,
    output logic [ADDR_WIDTH-1:0]                 o_mem_addr,
    output logic [VEC_SIZE-1:0]                   o_mem_wdata,
    input  logic                                  i_mem_ack,
    input  logic [VEC_SIZE-1:0]                   i_mem_rdata,
    output logic [VEC_INDEX_WIDTH-1:0]            o_vrf_raddr,
    input  logic [VEC_LANES-1:0][VEC_SIZE-1:0]    i_vrf_rdata,
    output logic                                  o_vrf_we,
    output logic [VEC_INDEX_WIDTH-1:0]            o_vrf_waddr,
    output logic [VEC_LANES-1:0][VEC_SIZE-1:0]    o_vrf_wdata
);

    state_e                               state_q, state_d;
    cmd_t                                 cmd_q, cmd_d;
    logic [LANE_IDX_W-1:0]                idx_q, idx_d;
    logic [VEC_LANES-1:0][VEC_SIZE-1:0]   lane_buf_q, lane_buf_d;

    logic                                 cmd_ready_q, cmd_ready_d;
    logic                                 done_q, done_d;
    logic                                 mem_req_q, mem_req_d;
    logic                                 mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]                mem_addr_q, mem_addr_d;
    logic [VEC_SIZE-1:0]                  mem_wdata_q, mem_wdata_d;
    logic [VEC_INDEX_WIDTH-1:0]           vrf_raddr_q, vrf_raddr_d;
    logic                                 vrf_we_q, vrf_we_d;
    logic [VEC_INDEX_WIDTH-1:0]           vrf_waddr_q, vrf_waddr_d;

    logic                                 accept;
    logic                                 last_lane;

    assign accept    = i_cmd_valid && cmd_ready_q;
    assign last_lane = (idx_q == LANE_IDX_W'(VEC_LANES - 1));

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        idx_d      = idx_q;
        lane_buf_d = lane_buf_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cmd_d.store = i_cmd_store;
                    cmd_d.vreg  = i_cmd_vreg;
                    cmd_d.base  = i_cmd_base;
                    idx_d       = '0;
                    state_d     = i_cmd_store ? ST_VRD : ST_MEM;
                end
            end
            ST_VRD: begin
                lane_buf_d = i_vrf_rdata;
                state_d    = ST_MEM;
            end
            ST_MEM: begin
                // Acks only count while a request is actually outstanding.
                if (i_mem_ack && mem_req_q) begin
                    if (!cmd_q.store) begin
                        lane_buf_d[idx_q] = i_mem_rdata;
                    end
                    idx_d = idx_q + 1'b1;
                    if (last_lane) begin
                        state_d = cmd_q.store ? ST_DONE : ST_VWR;
                    end
                end
            end
            ST_VWR:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next-state values so they leave flops aligned with the state.
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        done_d      = (state_d == ST_DONE);
        mem_req_d   = (state_d == ST_MEM);
        mem_we_d    = (state_d == ST_MEM) && cmd_d.store;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        vrf_raddr_d = '0;
        vrf_we_d    = (state_d == ST_VWR);
        vrf_waddr_d = '0;

        if (state_d == ST_MEM) begin
            mem_addr_d = lane_addr(cmd_d.base, idx_d);
            if (cmd_d.store) begin
                mem_wdata_d = lane_buf_d[idx_d];
            end
        end
        if (state_d == ST_VRD) begin
            vrf_raddr_d = cmd_d.vreg;
        end
        if (state_d == ST_VWR) begin
            vrf_waddr_d = cmd_d.vreg;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            idx_q       <= '0;
            lane_buf_q  <= '0;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            vrf_raddr_q <= '0;
            vrf_we_q    <= 1'b0;
            vrf_waddr_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            idx_q       <= idx_d;
            lane_buf_q  <= lane_buf_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            vrf_raddr_q <= vrf_raddr_d;
            vrf_we_q    <= vrf_we_d;
            vrf_waddr_q <= vrf_waddr_d;
        end
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_done      = done_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_vrf_raddr = vrf_raddr_q;
    assign o_vrf_we    = vrf_we_q;
    assign o_vrf_waddr = vrf_waddr_q;
    assign o_vrf_wdata = lane_buf_q;

endmodule

// File: tb/tb_vec_load_store.sv
// Directed bench for vec_load_store: memory and VRF models, event logging,
// hand-computed expectations.
module tb_vec_load_store;

    logic              clk;
    logic              rst_b;
    logic              cmd_valid, cmd_ready, cmd_store;
    logic [2:0]        cmd_vreg;
    logic [15:0]       cmd_base;
    logic              done;
    logic              mem_req, mem_we, mem_ack;
    logic [15:0]       mem_addr;
    logic [7:0]        mem_wdata, mem_rdata;
    logic [2:0]        vrf_raddr, vrf_waddr;
    logic [15:0][7:0]  vrf_rdata, vrf_wdata;
    logic              vrf_we;

    logic [7:0]        mem [0:65535];
    logic [15:0][7:0]  vrf [0:7];

    int cyc = 0;
    int acc_cnt = 0, ack_cnt = 0, vwe_cnt = 0, done_cnt = 0;
    int acc_cyc [0:15];
    int vwe_cyc = 0, done_cyc = 0;
    logic [2:0]       vwe_addr;
    logic [15:0][7:0] vwe_data;
    int               log_n = 0;
    logic [15:0]      log_addr [0:63];
    logic [7:0]       log_data [0:63];
    logic             log_we   [0:63];

    int   ack_div = 1;
    int   wcnt = 0;
    logic spurious = 1'b0;

    int total = 0, bad = 0;

    vec_load_store dut (
        .i_clk(clk), .i_rst(rst_b),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_store(cmd_store),
        .i_cmd_vreg(cmd_vreg), .i_cmd_base(cmd_base), .o_done(done),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_vrf_raddr(vrf_raddr), .i_vrf_rdata(vrf_rdata), .o_vrf_we(vrf_we),
        .o_vrf_waddr(vrf_waddr), .o_vrf_wdata(vrf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign vrf_rdata = vrf[vrf_raddr];

    // Memory responder: decides the ack for the coming edge.
    always @(negedge clk) begin
        mem_rdata = mem[mem_addr];
        if (mem_req) begin
            if (wcnt >= ack_div - 1) begin
                mem_ack = 1'b1;
                wcnt    = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt    = wcnt + 1;
            end
        end else begin
            mem_ack = spurious;
            wcnt    = 0;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_b) begin
            if (cmd_valid && cmd_ready) begin
                acc_cyc[acc_cnt % 16] = cyc;
                acc_cnt = acc_cnt + 1;
            end
            if (mem_req && mem_ack) begin
                if (mem_we) mem[mem_addr] = mem_wdata;
                log_addr[log_n % 64] = mem_addr;
                log_data[log_n % 64] = mem_we ? mem_wdata : mem[mem_addr];
                log_we[log_n % 64]   = mem_we;
                log_n   = log_n + 1;
                ack_cnt = ack_cnt + 1;
            end
            if (vrf_we) begin
                vwe_cyc  = cyc;
                vwe_addr = vrf_waddr;
                vwe_data = vrf_wdata;
                vwe_cnt  = vwe_cnt + 1;
            end
            if (done) begin
                done_cyc = cyc;
                done_cnt = done_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] vr, input logic [15:0] base);
        int start;
        int k;
        start = acc_cnt;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_store = st; cmd_vreg = vr; cmd_base = base;
        k = 0;
        while (acc_cnt == start && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (acc_cnt == start) check("accept_timeout", 0, 1);
        cmd_valid = 1'b0; cmd_store = ~st; cmd_vreg = ~vr; cmd_base = ~base;
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (done_cnt < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt < target) check("done_timeout", 0, 1);
    endtask

    logic [15:0][7:0] exp_vec;
    int d0, v0, a0;

    initial begin
        rst_b = 1'b0; cmd_valid = 1'b0; cmd_store = 1'b0; cmd_vreg = '0; cmd_base = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int r = 0; r < 8; r++) vrf[r] = '0;
        for (int i = 0; i < 16; i++) begin
            mem[16'h0100 + i] = 8'(i + 1);
            vrf[5][i] = 8'(8'hA0 + i);
            vrf[7][i] = 8'(8'h50 + i);
            mem[16'(16'hFFF8 + i)] = 8'(8'h30 + i);
        end
        repeat (3) @(negedge clk);
        check("rst_ready",  {127'b0, cmd_ready}, 1);
        check("rst_req",    {127'b0, mem_req}, 0);
        check("rst_done",   {127'b0, done}, 0);
        check("rst_vwe",    {127'b0, vrf_we}, 0);
        check("rst_addr",   {112'b0, mem_addr}, 0);
        check("rst_vwdata", vrf_wdata, 0);
        rst_b = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {127'b0, cmd_ready}, 1);

        // LOAD vreg 2 from 0x0100, zero wait states
        for (int i = 0; i < 16; i++) exp_vec[i] = 8'(i + 1);
        d0 = done_cnt; v0 = vwe_cnt; a0 = ack_cnt; log_n = 0;
        issue(1'b0, 3'd2, 16'h0100);
        wait_done(d0 + 1);
        check("ld1_vwe_cnt", 128'(vwe_cnt - v0), 1);
        check("ld1_waddr", {125'b0, vwe_addr}, 2);
        check("ld1_wdata", vwe_data, exp_vec);
        check("ld1_vwe_lat", 128'(vwe_cyc - acc_cyc[(acc_cnt-1)%16]), 17);
        check("ld1_done_lat", 128'(done_cyc - acc_cyc[(acc_cnt-1)%16]), 18);
        check("ld1_acks", 128'(ack_cnt - a0), 16);
        for (int i = 0; i < 16; i++) check("ld1_rd_addr", {112'b0, log_addr[i]}, 128'(16'h0100 + i));

        // STORE vreg 5 to 0x0200, ack every third cycle
        ack_div = 3;
        d0 = done_cnt; a0 = ack_cnt; log_n = 0;
        issue(1'b1, 3'd5, 16'h0200);
        wait_done(d0 + 1);
        repeat (3) @(negedge clk);
        check("st_writes", 128'(ack_cnt - a0), 16);
        check("st_done_cnt", 128'(done_cnt - d0), 1);
        for (int i = 0; i < 16; i++) begin
            check("st_we",   {127'b0, log_we[i]}, 1);
            check("st_addr", {112'b0, log_addr[i]}, 128'(16'h0200 + i));
            check("st_data", {120'b0, log_data[i]}, 128'(8'hA0 + i));
        end

        // LOAD across the top of the address space
        ack_div = 1;
        for (int i = 0; i < 16; i++) exp_vec[i] = 8'(8'h30 + i);
        d0 = done_cnt; log_n = 0;
        issue(1'b0, 3'd3, 16'hFFF8);
        wait_done(d0 + 1);
        check("wrap_addr7", {112'b0, log_addr[7]}, 128'h0000_FFFF);
        check("wrap_addr8", {112'b0, log_addr[8]}, 128'h0000_0000);
        check("wrap_addr15", {112'b0, log_addr[15]}, 128'h0000_0007);
        check("wrap_waddr", {125'b0, vwe_addr}, 3);
        check("wrap_wdata", vwe_data, exp_vec);

        // Reset during the seventh ack of a LOAD
        d0 = done_cnt; v0 = vwe_cnt; a0 = ack_cnt;
        issue(1'b0, 3'd4, 16'h0300);
        begin
            int k;
            k = 0;
            while (ack_cnt - a0 < 6 && k < 100) begin
                @(negedge clk);
                k++;
            end
        end
        check("rst_mid_req_before", {127'b0, mem_req}, 1);
        rst_b = 1'b0;
        @(negedge clk);
        check("rst_mid_req", {127'b0, mem_req}, 0);
        rst_b = 1'b1;
        repeat (25) @(negedge clk);
        check("rst_mid_vwe", 128'(vwe_cnt - v0), 0);
        check("rst_mid_done", 128'(done_cnt - d0), 0);
        check("rst_mid_acks", 128'(ack_cnt - a0), 6);
        for (int i = 0; i < 16; i++) exp_vec[i] = 8'(i + 1);
        d0 = done_cnt;
        issue(1'b0, 3'd1, 16'h0100);
        wait_done(d0 + 1);
        check("post_rst_waddr", {125'b0, vwe_addr}, 1);
        check("post_rst_wdata", vwe_data, exp_vec);

        // Back-to-back commands with valid held, fields changed mid-command, spurious acks
        spurious = 1'b1;
        d0 = done_cnt; v0 = vwe_cnt; a0 = acc_cnt; log_n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_store = 1'b0; cmd_vreg = 3'd6; cmd_base = 16'h0100;
        begin
            int k;
            k = 0;
            while (acc_cnt == a0 && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        cmd_store = 1'b1; cmd_vreg = 3'd7; cmd_base = 16'h0500;
        begin
            int k;
            k = 0;
            while (acc_cnt < a0 + 2 && k < 100) begin
                @(negedge clk);
                k++;
            end
        end
        cmd_valid = 1'b0;
        check("b2b_accepts", 128'(acc_cnt - a0), 2);
        check("b2b_gap", 128'(acc_cyc[(a0+1)%16] - acc_cyc[a0%16]), 19);
        check("b2b_first_done", 128'(done_cyc - acc_cyc[a0%16]), 18);
        check("b2b_waddr", {125'b0, vwe_addr}, 6);
        check("b2b_wdata", vwe_data, exp_vec);
        wait_done(d0 + 2);
        repeat (3) @(negedge clk);
        spurious = 1'b0;
        check("b2b_done_cnt", 128'(done_cnt - d0), 2);
        check("b2b_vwe_cnt", 128'(vwe_cnt - v0), 1);
        check("b2b_log_n", 128'(log_n), 32);
        for (int i = 0; i < 16; i++) begin
            check("b2b_st_addr", {112'b0, log_addr[16 + i]}, 128'(16'h0500 + i));
            check("b2b_st_data", {120'b0, log_data[16 + i]}, 128'(8'h50 + i));
        end
        check("b2b_idle_ready", {127'b0, cmd_ready}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
